// File: rtl/player_pkg.sv
// Shared definitions for the music player: controller state encoding and default
// song-table sizing used by the song ROM and note sequencer.
package player_pkg;

    localparam int unsigned N_SONGS_DEF = 4;
    localparam int unsigned IDX_W_DEF   = 2;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_PLAY  = 2'd2,
        ST_PAUSE = 2'd3
    } state_e;

endpackage

// File: rtl/btn_pulse.sv
// Raw pushbutton front end: two-flop synchronizer followed by a rising-edge detector
// that yields one clock-wide pulse per press, however long the button is held.
module btn_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= btn_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign pulse_o = s2_q & ~s3_q;

endmodule

// File: rtl/player_ctrl.sv
// Front-panel sequencer: cleans the play/next/prev buttons, arbitrates them under a
// lockout window and runs the stop/load/play/pause machine driving the note sequencer.
module player_ctrl
    import player_pkg::*;
#(
    parameter int unsigned N_SONGS     = N_SONGS_DEF,
    parameter int unsigned IDX_W       = IDX_W_DEF,
    parameter int unsigned LOCK_CYCLES = 1000000,
    parameter int unsigned LOCK_W      = 20,
    parameter int unsigned AUTO_NEXT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_play,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             song_end,
    output logic             playing,
    output logic [IDX_W-1:0] song_idx,
    output logic             restart,
    output logic             busy
);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_SONGS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

    logic p_play, p_next, p_prev;

    btn_pulse u_play (.clk(clk), .rst_n(rst_n), .btn_i(btn_play), .pulse_o(p_play));
    btn_pulse u_next (.clk(clk), .rst_n(rst_n), .btn_i(btn_next), .pulse_o(p_next));
    btn_pulse u_prev (.clk(clk), .rst_n(rst_n), .btn_i(btn_prev), .pulse_o(p_prev));

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             restart_q, restart_d;
    logic             playing_q, playing_d;
    logic [LOCK_W-1:0] lock_q, lock_d;

    logic accept_ok, press_play, press_next, press_prev, accepted;
    logic [IDX_W-1:0] idx_inc, idx_dec;

    // A high restart_q blocks presses so the reload strobe can never repeat back-to-back.
    assign accept_ok  = (lock_q == '0) & ~restart_q & (state_q != ST_LOAD);
    assign press_play = accept_ok & p_play;
    assign press_next = accept_ok & p_next & ~p_play;
    assign press_prev = accept_ok & p_prev & ~p_play & ~p_next;
    assign accepted   = press_play | press_next | press_prev;

    assign idx_inc = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_ONE;
    assign idx_dec = (idx_q == '0) ? LAST_IDX : idx_q - IDX_ONE;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        restart_d = 1'b0;
        lock_d    = (lock_q != '0) ? lock_q - LOCK_ONE : lock_q;
        if (accepted) begin
            lock_d = LOCK_LOAD;
        end

        case (state_q)
            ST_STOP: begin
                if (press_play) begin
                    state_d = ST_LOAD;
                end else if (press_next) begin
                    idx_d = idx_inc;
                end else if (press_prev) begin
                    idx_d = idx_dec;
                end
            end
            ST_LOAD: state_d = ST_PLAY;
            ST_PLAY: begin
                if (press_play) begin
                    state_d = ST_PAUSE;
                end else if (press_next) begin
                    idx_d   = idx_inc;
                    state_d = ST_LOAD;
                end else if (press_prev) begin
                    idx_d   = idx_dec;
                    state_d = ST_LOAD;
                end else if (song_end) begin
                    if (AUTO_NEXT != 0) begin
                        idx_d   = idx_inc;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_PAUSE: begin
                if (press_play) begin
                    state_d = ST_PLAY;
                end else if (press_next) begin
                    idx_d     = idx_inc;
                    restart_d = 1'b1;
                end else if (press_prev) begin
                    idx_d     = idx_dec;
                    restart_d = 1'b1;
                end
            end
            default: state_d = ST_STOP;
        endcase

        if (state_d == ST_LOAD) begin
            restart_d = 1'b1;
        end
        playing_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_STOP;
            idx_q     <= '0;
            restart_q <= 1'b0;
            playing_q <= 1'b0;
            lock_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            restart_q <= restart_d;
            playing_q <= playing_d;
            lock_q    <= lock_d;
        end
    end

    assign playing  = playing_q;
    assign song_idx = idx_q;
    assign restart  = restart_q;
    assign busy     = (lock_q != '0);

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: cycle-exact hand sequences for press timing, lockout and reset,
// then a vector table of panel operations whose expected outcomes flow through a queue.
module tb_player_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_play = 1'b0, btn_next = 1'b0, btn_prev = 1'b0, song_end = 1'b0;
    logic       playing, restart, busy;
    logic [1:0] song_idx;

    logic       b0_play = 1'b0, se0 = 1'b0;
    logic       playing0, restart0, busy0;
    logic [1:0] idx0;

    int checks = 0;
    int errors = 0;
    int rtot = 0;
    int dbl = 0;
    logic rprev = 1'b0;

    always #5 clk = ~clk;

    player_ctrl #(
        .N_SONGS(3), .IDX_W(2), .LOCK_CYCLES(8), .LOCK_W(3), .AUTO_NEXT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_play(btn_play), .btn_next(btn_next),
        .btn_prev(btn_prev), .song_end(song_end), .playing(playing),
        .song_idx(song_idx), .restart(restart), .busy(busy)
    );

    player_ctrl #(
        .N_SONGS(3), .IDX_W(2), .LOCK_CYCLES(8), .LOCK_W(3), .AUTO_NEXT(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .btn_play(b0_play), .btn_next(1'b0),
        .btn_prev(1'b0), .song_end(se0), .playing(playing0),
        .song_idx(idx0), .restart(restart0), .busy(busy0)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (restart === 1'b1) rtot <= rtot + 1;
            if (restart === 1'b1 && rprev) dbl <= dbl + 1;
            rprev <= (restart === 1'b1);
        end else begin
            rprev <= 1'b0;
        end
    end

    typedef enum int {OpPlay, OpNext, OpPrev, OpEnd, OpPlayNext, OpPrevEnd} op_e;
    typedef struct {
        op_e        op;
        logic       exp_play;
        logic [1:0] exp_idx;
        int         exp_rst;
    } vec_t;

    vec_t vecs[17];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Buttons go high just before edge 0; a same-cycle song_end is aligned with the pulse.
    task automatic apply(input op_e op);
        if (op == OpEnd) begin
            song_end = 1'b1;
            cyc(1);
            song_end = 1'b0;
        end else begin
            btn_play = (op == OpPlay) || (op == OpPlayNext);
            btn_next = (op == OpNext) || (op == OpPlayNext);
            btn_prev = (op == OpPrev) || (op == OpPrevEnd);
            cyc(2);
            song_end = (op == OpPrevEnd);
            cyc(1);
            song_end = 1'b0;
            btn_play = 1'b0;
            btn_next = 1'b0;
            btn_prev = 1'b0;
        end
        cyc(14);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);
    endtask

    initial begin
        int r0;
        vec_t e;

        vecs[0]  = '{OpNext,     1'b0, 2'd1, 0};
        vecs[1]  = '{OpNext,     1'b0, 2'd2, 0};
        vecs[2]  = '{OpNext,     1'b0, 2'd0, 0};
        vecs[3]  = '{OpPrev,     1'b0, 2'd2, 0};
        vecs[4]  = '{OpPrev,     1'b0, 2'd1, 0};
        vecs[5]  = '{OpPlay,     1'b1, 2'd1, 1};
        vecs[6]  = '{OpEnd,      1'b1, 2'd2, 1};
        vecs[7]  = '{OpEnd,      1'b1, 2'd0, 1};
        vecs[8]  = '{OpPrevEnd,  1'b1, 2'd2, 1};
        vecs[9]  = '{OpPlayNext, 1'b0, 2'd2, 0};
        vecs[10] = '{OpEnd,      1'b0, 2'd2, 0};
        vecs[11] = '{OpNext,     1'b0, 2'd0, 1};
        vecs[12] = '{OpPrev,     1'b0, 2'd2, 1};
        vecs[13] = '{OpPlay,     1'b1, 2'd2, 0};
        vecs[14] = '{OpNext,     1'b1, 2'd0, 1};
        vecs[15] = '{OpPrev,     1'b1, 2'd2, 1};
        vecs[16] = '{OpPlay,     1'b0, 2'd2, 0};

        // Reset values, both instances.
        cyc(3);
        chk("rst_playing", {31'd0, playing}, 0);
        chk("rst_idx", {30'd0, song_idx}, 0);
        chk("rst_restart", {31'd0, restart}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst0_all", {28'd0, playing0, idx0, restart0 | busy0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);

        // Play from STOP, held for 20 cycles: one event, exact pulse timing.
        btn_play = 1'b1;
        for (int c = 0; c < 25; c++) begin
            cyc(1);
            if (c == 19) btn_play = 1'b0;
            chk($sformatf("hold_restart_e%0d", c), {31'd0, restart}, {31'd0, c == 2});
            chk($sformatf("hold_playing_e%0d", c), {31'd0, playing}, {31'd0, c >= 3});
            chk($sformatf("hold_busy_e%0d", c), {31'd0, busy}, {31'd0, c >= 2 && c <= 8});
        end
        chk("hold_idx", {30'd0, song_idx}, 0);

        // Asynchronous reset mid-lockout while playing idx 1, then normal operation.
        do_reset();
        apply(OpNext);
        btn_play = 1'b1;
        cyc(5);
        chk("pre_rst_playing", {31'd0, playing}, 1);
        chk("pre_rst_idx", {30'd0, song_idx}, 1);
        chk("pre_rst_busy", {31'd0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_playing", {31'd0, playing}, 0);
        chk("arst_idx", {30'd0, song_idx}, 0);
        chk("arst_restart", {31'd0, restart}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        btn_play = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);
        r0 = rtot;
        apply(OpPlay);
        chk("post_rst_playing", {31'd0, playing}, 1);
        chk("post_rst_restarts", rtot - r0, 1);

        // Lockout: a pulse 4 cycles after an accepted press is dropped, 9 cycles is taken.
        r0 = rtot;
        btn_next = 1'b1;
        cyc(2);
        btn_next = 1'b0;
        cyc(2);
        btn_prev = 1'b1;
        cyc(2);
        btn_prev = 1'b0;
        cyc(2);
        chk("lock_first_idx", {30'd0, song_idx}, 1);
        cyc(1);
        btn_next = 1'b1;
        cyc(2);
        btn_next = 1'b0;
        cyc(14);
        chk("lock_second_idx", {30'd0, song_idx}, 2);
        chk("lock_playing", {31'd0, playing}, 1);
        chk("lock_restarts", rtot - r0, 2);

        // AUTO_NEXT=0 instance: song_end stops and keeps the index.
        b0_play = 1'b1;
        cyc(3);
        b0_play = 1'b0;
        cyc(14);
        chk("an0_playing", {31'd0, playing0}, 1);
        se0 = 1'b1;
        cyc(1);
        se0 = 1'b0;
        cyc(4);
        chk("an0_end_playing", {31'd0, playing0}, 0);
        chk("an0_end_idx", {30'd0, idx0}, 0);

        // Table-driven operation sequence from a fresh reset.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            sb.push_back(vecs[i]);
            r0 = rtot;
            apply(vecs[i].op);
            e = sb.pop_front();
            chk($sformatf("vec%0d_playing", i), {31'd0, playing}, {31'd0, e.exp_play});
            chk($sformatf("vec%0d_idx", i), {30'd0, song_idx}, {30'd0, e.exp_idx});
            chk($sformatf("vec%0d_restarts", i), rtot - r0, e.exp_rst);
        end

        chk("restart_back_to_back", dbl, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
